// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-capture receiver: measurement states,
// default frame timing and the duty-width derivation.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } meas_state_e;

  localparam int unsigned N_CH_DEF    = 8;
  localparam int unsigned PERIOD_DEF  = 256;
  localparam int unsigned TIMEOUT_DEF = 512;

  function automatic int unsigned duty_w(input int unsigned period);
    return $clog2(period);
  endfunction

endpackage

// File: rtl/pwm_chan_meas.sv
// One PWM channel: synchronizer, post-reset settle window, pulse/period
// measurement FSM and flat-line timeout.
module pwm_chan_meas
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD      = PERIOD_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  parameter int unsigned DUTY_W      = duty_w(PERIOD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_vld_o,
  output logic              stuck_o,
  output logic              prd_err_o
);

  localparam int unsigned HI_W   = DUTY_W + 1;
  localparam int unsigned PER_W  = DUTY_W + 2;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC);

  localparam logic [HI_W-1:0]   HI_MAX     = '1;
  localparam logic [HI_W-1:0]   HI_CAP     = HI_W'(PERIOD - 1);
  localparam logic [PER_W-1:0]  PER_SAT    = PER_W'(2 * PERIOD);
  localparam logic [PER_W-1:0]  PER_NOM    = PER_W'(PERIOD);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX   = DUTY_W'(PERIOD - 1);

  meas_state_e       state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]        settle_q, settle_d;
  logic [HI_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              duty_vld_q, duty_vld_d;
  logic              stuck_q, stuck_d;
  logic              prd_err_q, prd_err_d;

  logic settled, rise, fall, edge_det, timeout;

  assign settled  = (settle_q == 2'd3);
  assign rise     = settled & s2_q & ~s3_q;
  assign fall     = settled & ~s2_q & s3_q;
  assign edge_det = rise | fall;
  assign timeout  = ~edge_det & (idle_cnt_q == IDLE_LAST);

  always_comb begin
    s1_d       = pwm_i;
    s2_d       = s1_q;
    s3_d       = s2_q;
    settle_d   = settled ? settle_q : settle_q + 2'd1;
    state_d    = state_q;
    hi_cnt_d   = hi_cnt_q;
    per_cnt_d  = per_cnt_q;
    duty_d     = duty_q;
    duty_vld_d = 1'b0;
    stuck_d    = stuck_q;
    prd_err_d  = prd_err_q;
    idle_cnt_d = idle_cnt_q + 1'b1;

    if (edge_det) begin
      idle_cnt_d = '0;
      stuck_d    = 1'b0;
    end

    unique case (state_q)
      ST_WAIT: begin
        if (rise) begin
          state_d   = ST_HIGH;
          hi_cnt_d  = HI_W'(1);
          per_cnt_d = PER_W'(1);
        end
      end
      ST_HIGH: begin
        if (hi_cnt_q != HI_MAX) hi_cnt_d = hi_cnt_q + 1'b1;
        if (per_cnt_q != PER_SAT) per_cnt_d = per_cnt_q + 1'b1;
        if (fall) begin
          duty_d     = (hi_cnt_q > HI_CAP) ? DUTY_MAX : hi_cnt_q[DUTY_W-1:0];
          duty_vld_d = 1'b1;
          state_d    = ST_LOW;
        end
      end
      ST_LOW: begin
        if (per_cnt_q != PER_SAT) per_cnt_d = per_cnt_q + 1'b1;
        if (rise) begin
          prd_err_d = (per_cnt_q != PER_NOM);
          hi_cnt_d  = HI_W'(1);
          per_cnt_d = PER_W'(1);
          state_d   = ST_HIGH;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // Timeout only fires on an edge-free cycle, so it never competes with a fall publish.
    if (timeout) begin
      duty_d     = s2_q ? DUTY_MAX : '0;
      duty_vld_d = 1'b1;
      stuck_d    = 1'b1;
      idle_cnt_d = '0;
      state_d    = ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      settle_q   <= '0;
      hi_cnt_q   <= '0;
      per_cnt_q  <= '0;
      idle_cnt_q <= '0;
      duty_q     <= '0;
      duty_vld_q <= 1'b0;
      stuck_q    <= 1'b0;
      prd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      settle_q   <= settle_d;
      hi_cnt_q   <= hi_cnt_d;
      per_cnt_q  <= per_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      duty_q     <= duty_d;
      duty_vld_q <= duty_vld_d;
      stuck_q    <= stuck_d;
      prd_err_q  <= prd_err_d;
    end
  end

  assign duty_o     = duty_q;
  assign duty_vld_o = duty_vld_q;
  assign stuck_o    = stuck_q;
  assign prd_err_o  = prd_err_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Multi-channel PWM duty recovery: one independent measurement slice per
// line, outputs packed channel-major onto flat buses.
module pwm_duty_capture
  import pwm_pkg::*;
#(
  parameter  int unsigned N_CH        = N_CH_DEF,
  parameter  int unsigned PERIOD      = PERIOD_DEF,
  parameter  int unsigned TIMEOUT_CYC = TIMEOUT_DEF,
  localparam int unsigned DUTY_W      = duty_w(PERIOD)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          pwm_in,
  output logic [N_CH*DUTY_W-1:0]   duty_o,
  output logic [N_CH-1:0]          duty_vld_o,
  output logic [N_CH-1:0]          stuck_o,
  output logic [N_CH-1:0]          prd_err_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwm_chan_meas #(
      .PERIOD      (PERIOD),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .DUTY_W      (DUTY_W)
    ) u_meas (
      .clk        (clk),
      .rst_n      (rst_n),
      .pwm_i      (pwm_in[c]),
      .duty_o     (duty_o[c*DUTY_W +: DUTY_W]),
      .duty_vld_o (duty_vld_o[c]),
      .stuck_o    (stuck_o[c]),
      .prd_err_o  (prd_err_o[c])
    );
  end

endmodule
